// File: rtl/rvx_core_load_sequencer_pkg.sv
// Shared types and helpers for the load sequencer: state encoding, load size codes
// and the word-span / misalignment predicates.
package rvx_core_load_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_LO = 3'd1,
        ST_WAIT_LO  = 3'd2,
        ST_ISSUE_HI = 3'd3,
        ST_WAIT_HI  = 3'd4,
        ST_RESULT   = 3'd5
    } seq_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // size code 2'b11 is treated as a word everywhere
    function automatic logic f_spans(input logic [1:0] off, input logic [1:0] size);
        return ((size == SIZE_HALF) && (off == 2'd3)) || (size[1] && (off != 2'd0));
    endfunction

    function automatic logic f_misaligned(input logic [1:0] off, input logic [1:0] size);
        return ((size == SIZE_HALF) && off[0]) || (size[1] && (off != 2'd0));
    endfunction

endpackage

// File: rtl/rvx_core_load_sequencer_if.sv
// Load request / data bus / writeback bundle. The slave modport is the sequencer,
// the master modport is the surrounding core and memory.
interface rvx_core_load_sequencer_if;
    logic        load_request_valid;
    logic        load_request_ready;
    logic [31:0] load_address;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic        load_flush;
    logic [31:0] mem_address;
    logic        mem_read_request;
    logic        mem_read_ready;
    logic        mem_read_valid;
    logic [31:0] mem_read_data;
    logic        load_result_valid;
    logic [31:0] load_result_data;
    logic        load_misaligned;

    modport slave (
        input  load_request_valid, load_address, load_size, load_unsigned, load_flush,
        input  mem_read_ready, mem_read_valid, mem_read_data,
        output load_request_ready, mem_address, mem_read_request,
        output load_result_valid, load_result_data, load_misaligned
    );

    modport master (
        output load_request_valid, load_address, load_size, load_unsigned, load_flush,
        output mem_read_ready, mem_read_valid, mem_read_data,
        input  load_request_ready, mem_address, mem_read_request,
        input  load_result_valid, load_result_data, load_misaligned
    );
endinterface

// File: rtl/rvx_core_load_merge.sv
// Combinational load alignment: shifts {hi,lo} right by the byte offset, then
// truncates and sign/zero-extends to the load size.
module rvx_core_load_merge
    import rvx_core_load_sequencer_pkg::*;
(
    input  logic [31:0] i_lo_word,
    input  logic [31:0] i_hi_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);
    logic [63:0] w_cat;
    logic [31:0] w_aligned;

    assign w_cat     = {i_hi_word, i_lo_word};
    assign w_aligned = 32'(w_cat >> {i_offset, 3'b000});

    always_comb begin
        o_data = w_aligned;
        case (i_size)
            SIZE_BYTE: o_data = {{24{~i_unsigned & w_aligned[7]}}, w_aligned[7:0]};
            SIZE_HALF: o_data = {{16{~i_unsigned & w_aligned[15]}}, w_aligned[15:0]};
            default:   o_data = w_aligned;
        endcase
    end
endmodule

// File: rtl/rvx_core_load_sequencer.sv
// Load sequencer: one or two aligned bus reads per load, merged into a writeback result.
// RVX_MISALIGNED_LOAD_EN enables the two-read spanning path; otherwise misaligned loads trap.
//   state    | meaning
//   IDLE     | ready for a new load
//   ISSUE_LO | first word read requested
//   WAIT_LO  | waiting for first word data
//   ISSUE_HI | second (next word) read requested
//   WAIT_HI  | waiting for second word data
//   RESULT   | result or misaligned pulse for one cycle
module rvx_core_load_sequencer
    import rvx_core_load_sequencer_pkg::*;
(
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    rvx_core_load_sequencer_if.slave io_bus
);
    seq_state_e  r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_drop;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic        r_ready;
    logic        r_result_valid;
    logic [31:0] r_result_data;
    logic        r_misaligned;

    logic [31:0] w_lo_in;
    logic [31:0] w_hi_in;
    logic [31:0] w_merged;
    logic        w_spans;
    logic        w_mis_req;

`ifdef RVX_MISALIGNED_LOAD_EN
    assign w_spans   = f_spans(r_addr[1:0], r_size);
    assign w_mis_req = 1'b0;
`else
    assign w_spans   = 1'b0;
    assign w_mis_req = f_misaligned(io_bus.load_address[1:0], io_bus.load_size);
`endif

    // feed the bus data straight into the merge so the result registers on the data edge
    assign w_lo_in = (r_state == ST_WAIT_LO) ? io_bus.mem_read_data : r_lo;
    assign w_hi_in = (r_state == ST_WAIT_HI) ? io_bus.mem_read_data : r_hi;

    rvx_core_load_merge u_merge (
        .i_lo_word  (w_lo_in),
        .i_hi_word  (w_hi_in),
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_merged)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_size         <= '0;
            r_unsigned     <= 1'b0;
            r_drop         <= 1'b0;
            r_lo           <= '0;
            r_hi           <= '0;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            r_ready        <= 1'b1;
            r_result_valid <= 1'b0;
            r_result_data  <= '0;
            r_misaligned   <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_misaligned   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.load_request_valid && !io_bus.load_flush) begin
                        r_addr     <= io_bus.load_address;
                        r_size     <= io_bus.load_size;
                        r_unsigned <= io_bus.load_unsigned;
                        r_drop     <= 1'b0;
                        r_hi       <= '0;
                        r_ready    <= 1'b0;
                        if (w_mis_req) begin
                            r_misaligned <= 1'b1;
                            r_state      <= ST_RESULT;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {io_bus.load_address[31:2], 2'b00};
                            r_state    <= ST_ISSUE_LO;
                        end
                    end
                end
                ST_ISSUE_LO, ST_ISSUE_HI: begin
                    if (io_bus.load_flush) begin
                        r_mem_req <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (io_bus.mem_read_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= (r_state == ST_ISSUE_LO) ? ST_WAIT_LO : ST_WAIT_HI;
                    end
                end
                ST_WAIT_LO, ST_WAIT_HI: begin
                    if (io_bus.mem_read_valid) begin
                        if (r_drop || io_bus.load_flush) begin
                            r_ready <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if ((r_state == ST_WAIT_LO) && w_spans) begin
                            r_lo       <= io_bus.mem_read_data;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {r_addr[31:2] + 30'd1, 2'b00};
                            r_state    <= ST_ISSUE_HI;
                        end else begin
                            r_result_valid <= 1'b1;
                            r_result_data  <= w_merged;
                            r_state        <= ST_RESULT;
                        end
                    end else if (io_bus.load_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_ready   <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // a flush masks the request and result in the same cycle it arrives
    assign io_bus.load_request_ready = r_ready;
    assign io_bus.mem_address        = r_mem_addr;
    assign io_bus.mem_read_request   = r_mem_req & ~io_bus.load_flush;
    assign io_bus.load_result_valid  = r_result_valid & ~io_bus.load_flush;
    assign io_bus.load_result_data   = r_result_data;
    assign io_bus.load_misaligned    = r_misaligned & ~io_bus.load_flush;
endmodule

// File: tb/tb_rvx_core_load_sequencer.sv
// Directed plus randomized bench for rvx_core_load_sequencer; expected values come from a
// byte-level little-endian memory model. Honors RVX_MISALIGNED_LOAD_EN like the design.
module tb_rvx_core_load_sequencer;
    import rvx_core_load_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rvx_core_load_sequencer_if bus ();

    rvx_core_load_sequencer dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .io_bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_ovr [logic [31:0]];
    logic [31:0] mem_seed = 32'h1234_5678;
    int          ready_delay = 0;
    int          resp_delay  = 0;
    logic [31:0] rd_q [$];

    int          g_nvalid, g_nmis, g_vlat, g_mlat, g_end;
    logic [31:0] g_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (mem_ovr.exists(wa)) return mem_ovr[wa];
        return (wa * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_rd({a[31:2], 2'b00});
        return 8'(w >> (8 * int'(a[1:0])));
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] a, input logic [1:0] sz,
                                               input logic u);
        int nb;
        logic [31:0] v;
        nb = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
        v  = '0;
        for (int i = 0; i < nb; i++) v |= 32'(byte_at(a + 32'(i))) << (8 * i);
        if (!u && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        return v;
    endfunction

    // memory responder: ready after ready_delay request cycles, data resp_delay cycles later
    initial begin : responder
        logic        pend, held;
        int          rdy_cnt, resp_cnt;
        logic [31:0] pend_addr, held_addr;
        pend = 1'b0; held = 1'b0; rdy_cnt = 0; resp_cnt = 0; pend_addr = '0; held_addr = '0;
        bus.mem_read_ready = 1'b0;
        bus.mem_read_valid = 1'b0;
        bus.mem_read_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.mem_read_valid = 1'b0;
            bus.mem_read_ready = 1'b0;
            if (!rst_n) begin
                pend = 1'b0; held = 1'b0; rdy_cnt = ready_delay;
                continue;
            end
            if (pend) begin
                if (resp_cnt == 0) begin
                    bus.mem_read_valid = 1'b1;
                    bus.mem_read_data  = mem_rd(pend_addr);
                    pend = 1'b0;
                end else resp_cnt--;
            end
            if (bus.mem_read_request) begin
                if (held) chk("addr_hold", bus.mem_address, held_addr);
                if (rdy_cnt == 0) begin
                    bus.mem_read_ready = 1'b1;
                    rd_q.push_back(bus.mem_address);
                    pend = 1'b1; pend_addr = bus.mem_address; resp_cnt = resp_delay;
                    held = 1'b0; rdy_cnt = ready_delay;
                end else begin
                    rdy_cnt--; held = 1'b1; held_addr = bus.mem_address;
                end
            end else begin
                held = 1'b0; rdy_cnt = ready_delay;
            end
        end
    end

    task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                            input int fc);
        g_nvalid = 0; g_nmis = 0; g_vlat = -1; g_mlat = -1; g_end = -1; g_data = 'x;
        rd_q.delete();
        @(negedge clk);
        bus.load_request_valid = 1'b1;
        bus.load_address       = a;
        bus.load_size          = sz;
        bus.load_unsigned      = u;
        bus.load_flush         = (fc == 0);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            bus.load_request_valid = 1'b0;
            bus.load_flush         = (c == fc);
            #2;
            if (bus.load_result_valid) begin g_nvalid++; g_vlat = c; g_data = bus.load_result_data; end
            if (bus.load_misaligned) begin g_nmis++; g_mlat = c; end
            if (bus.load_request_ready) begin g_end = c; break; end
        end
        bus.load_flush = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] a, input logic [1:0] sz,
                                 input logic u, input int dr, input int dv);
        int nb, nreads, lat;
        logic span, mis, mis_exp;
        logic [31:0] base;
        nb   = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
        span = (int'(a[1:0]) + nb) > 4;
        mis  = ((sz == SIZE_HALF) && a[0]) || ((sz == SIZE_WORD) && (a[1:0] != 2'd0));
`ifdef RVX_MISALIGNED_LOAD_EN
        mis_exp = 1'b0;
        nreads  = span ? 2 : 1;
`else
        mis_exp = mis;
        nreads  = mis ? 0 : 1;
`endif
        ready_delay = dr;
        resp_delay  = dv;
        run_load(a, sz, u, -1);
        if (mis_exp) begin
            chk({tag, "_mis"},    32'(g_nmis), 32'd1);
            chk({tag, "_valid"},  32'(g_nvalid), 32'd0);
            chk({tag, "_mislat"}, 32'(g_mlat), 32'd1);
            chk({tag, "_reads"},  32'(rd_q.size()), 32'd0);
            chk({tag, "_end"},    32'(g_end), 32'd2);
        end else begin
            lat  = 1 + nreads * (2 + dr + dv);
            base = {a[31:2], 2'b00};
            chk({tag, "_valid"}, 32'(g_nvalid), 32'd1);
            chk({tag, "_mis"},   32'(g_nmis), 32'd0);
            chk({tag, "_data"},  g_data, model_data(a, sz, u));
            chk({tag, "_lat"},   32'(g_vlat), 32'(lat));
            chk({tag, "_reads"}, 32'(rd_q.size()), 32'(nreads));
            for (int i = 0; i < rd_q.size() && i < nreads; i++)
                chk({tag, "_raddr"}, rd_q[i], base + 32'(4 * i));
            chk({tag, "_end"},   32'(g_end), 32'(lat + 1));
        end
    endtask

    initial begin : main
        int cnt;
        logic [31:0] a;
        bus.load_request_valid = 1'b0;
        bus.load_address       = '0;
        bus.load_size          = SIZE_WORD;
        bus.load_unsigned      = 1'b0;
        bus.load_flush         = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", 32'(bus.load_request_ready), 32'd1);
        chk("rst_req",   32'(bus.mem_read_request), 32'd0);
        chk("rst_addr",  bus.mem_address, 32'd0);
        chk("rst_valid", 32'(bus.load_result_valid), 32'd0);
        chk("rst_data",  bus.load_result_data, 32'd0);
        chk("rst_mis",   32'(bus.load_misaligned), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        mem_ovr[32'h100] = 32'hDEAD_BEEF;
        run_and_check("lw_aligned", 32'h100, SIZE_WORD, 1'b0, 0, 0);
        chk("lw_aligned_const", g_data, 32'hDEAD_BEEF);
        chk("lw_aligned_cyc3",  32'(g_vlat), 32'd3);
        repeat (3) @(negedge clk);
        #2 chk("data_hold", bus.load_result_data, 32'hDEAD_BEEF);

        mem_ovr[32'h100] = 32'h8012_3456;
        run_and_check("lb_signed", 32'h103, SIZE_BYTE, 1'b0, 0, 0);
        chk("lb_signed_const", g_data, 32'hFFFF_FF80);
        run_and_check("lbu", 32'h103, SIZE_BYTE, 1'b1, 0, 0);
        chk("lbu_const", g_data, 32'h0000_0080);

        mem_ovr[32'h100] = 32'h4433_2211;
        mem_ovr[32'h104] = 32'h8877_6655;
        run_and_check("lw_span", 32'h102, SIZE_WORD, 1'b0, 0, 0);
`ifdef RVX_MISALIGNED_LOAD_EN
        chk("lw_span_const", g_data, 32'h6655_4433);
        chk("lw_span_cyc5",  32'(g_vlat), 32'd5);
`endif
        run_and_check("lh_103", 32'h103, SIZE_HALF, 1'b0, 0, 0);
        run_and_check("lh_101", 32'h101, SIZE_HALF, 1'b1, 0, 0);

        // flush in WAIT_LO with a slow response: response absorbed, no result
        ready_delay = 0; resp_delay = 3;
        run_load(32'h200, SIZE_WORD, 1'b0, 2);
        chk("flush_wait_valid", 32'(g_nvalid), 32'd0);
        chk("flush_wait_end",   32'(g_end), 32'd6);
        chk("flush_wait_reads", 32'(rd_q.size()), 32'd1);
        run_and_check("after_flush", 32'h204, SIZE_WORD, 1'b0, 0, 0);

        ready_delay = 2; resp_delay = 0;
        run_load(32'h300, SIZE_WORD, 1'b0, 1);
        chk("flush_issue_reads", 32'(rd_q.size()), 32'd0);
        chk("flush_issue_end",   32'(g_end), 32'd2);
        chk("flush_issue_valid", 32'(g_nvalid), 32'd0);

        ready_delay = 0; resp_delay = 0;
        run_load(32'h300, SIZE_WORD, 1'b0, 3);
        chk("flush_result_valid", 32'(g_nvalid), 32'd0);
        chk("flush_result_end",   32'(g_end), 32'd4);

        run_load(32'h300, SIZE_WORD, 1'b0, 0);
        chk("flush_accept_end",   32'(g_end), 32'd1);
        chk("flush_accept_reads", 32'(rd_q.size()), 32'd0);

        mem_ovr.delete();
        run_and_check("lw_wrap", 32'hFFFF_FFFE, SIZE_WORD, 1'b0, 2, 0);
        run_and_check("lw_wait", 32'h400, SIZE_WORD, 1'b1, 2, 1);

        // reset in WAIT_LO aborts without a result
        ready_delay = 0; resp_delay = 3;
        @(negedge clk);
        bus.load_request_valid = 1'b1;
        bus.load_address = 32'h500; bus.load_size = SIZE_WORD;
        @(negedge clk);
        bus.load_request_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("midrst_ready", 32'(bus.load_request_ready), 32'd1);
        chk("midrst_req",   32'(bus.mem_read_request), 32'd0);
        chk("midrst_addr",  bus.mem_address, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            #2 if (bus.load_result_valid) cnt++;
        end
        chk("midrst_no_result", 32'(cnt), 32'd0);
        run_and_check("after_rst", 32'h504, SIZE_HALF, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            mem_seed = $urandom;
            run_and_check("rand", a, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
